// File: rtl/ioexp_input_debounce.sv
// Per-bit debouncer and rise/fall/pending/irq generator for the i2c_ioexp input word.
// Define IOEXP_DB_GLITCH_EN to add the sticky glitch (aborted-transition) flags output.
module ioexp_input_debounce #(
    parameter int               WIDTH         = 16,
    parameter int               TICK_DIV_BITS = 10,
    parameter int               DB_COUNT      = 4,
    parameter logic [WIDTH-1:0] RESET_VAL     = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw,
    input  logic [WIDTH-1:0] irq_mask,
    input  logic [WIDTH-1:0] pending_clr,
    output logic [WIDTH-1:0] state,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] pending,
`ifdef IOEXP_DB_GLITCH_EN
    output logic [WIDTH-1:0] glitch,
`endif
    output logic             irq
);

    localparam int             CW       = $clog2(DB_COUNT + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DB_COUNT - 1);

    logic [TICK_DIV_BITS-1:0]   presc_q;
    logic                       tick;
    logic [WIDTH-1:0]           raw_q;
    logic [WIDTH-1:0][CW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]           state_q, state_d;
    logic [WIDTH-1:0]           rise_q, rise_d;
    logic [WIDTH-1:0]           fall_q, fall_d;
    logic [WIDTH-1:0]           pending_q, pending_d;
    logic                       irq_q, irq_d;
`ifdef IOEXP_DB_GLITCH_EN
    logic [WIDTH-1:0]           glitch_q, glitch_d, glitch_set;
`endif

    assign tick = &presc_q;

    always_comb begin
        cnt_d   = cnt_q;
        state_d = state_q;
        rise_d  = '0;
        fall_d  = '0;
`ifdef IOEXP_DB_GLITCH_EN
        glitch_set = '0;
`endif
        if (tick) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (raw_q[i] == state_q[i]) begin
                    cnt_d[i] = '0;
`ifdef IOEXP_DB_GLITCH_EN
                    glitch_set[i] = (cnt_q[i] != '0);
`endif
                end else if (cnt_q[i] == CNT_LAST) begin
                    cnt_d[i]   = '0;
                    state_d[i] = ~state_q[i];
                    rise_d[i]  = ~state_q[i];
                    fall_d[i]  = state_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Edge flags are taken from the visible pulses, so a clear landing on the
    // pulse cycle loses to the set.
    assign pending_d = (pending_q & ~pending_clr) | rise_q | fall_q;
    assign irq_d     = |(pending_q & ~irq_mask);
`ifdef IOEXP_DB_GLITCH_EN
    assign glitch_d  = (glitch_q & ~pending_clr) | glitch_set;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q   <= '0;
            raw_q     <= RESET_VAL;
            cnt_q     <= '0;
            state_q   <= RESET_VAL;
            rise_q    <= '0;
            fall_q    <= '0;
            pending_q <= '0;
            irq_q     <= 1'b0;
`ifdef IOEXP_DB_GLITCH_EN
            glitch_q  <= '0;
`endif
        end else begin
            presc_q   <= presc_q + 1'b1;
            raw_q     <= raw;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            pending_q <= pending_d;
            irq_q     <= irq_d;
`ifdef IOEXP_DB_GLITCH_EN
            glitch_q  <= glitch_d;
`endif
        end
    end

    assign state   = state_q;
    assign rise    = rise_q;
    assign fall    = fall_q;
    assign pending = pending_q;
    assign irq     = irq_q;
`ifdef IOEXP_DB_GLITCH_EN
    assign glitch  = glitch_q;
`endif

endmodule
